fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
- REQ-001 Parameter: DSIZE, default 8, data word width; equals the DSIZE of the feeding asynchronous FIFO.
- REQ-002 Parameter: CSIZE, default 16, width of the transfer counter (used only when the Configuration feature is compiled in).
- REQ-003 I_clk input 1: single clock, rising edge; same net as the FIFO read clock.
- REQ-004 I_rst_n input 1: asynchronous, active-low reset.
- REQ-005 I_fifo_rempty input 1: registered empty flag from the FIFO read side.
- REQ-006 O_fifo_rinc output 1: read-increment request to the FIFO.
- REQ-007 I_fifo_rdata input DSIZE: FIFO registered read data.
- REQ-008 O_valid output 1: output word available.
- REQ-009 I_ready input 1: consumer accepts the word.
- REQ-010 O_data output DSIZE: output word.
- REQ-011 O_occ output 2: words held in the output buffer, range 0..3.
- REQ-012 I_cnt_clr input 1, and O_xfer_cnt output CSIZE: present only with FIFO_RD_STREAM_CNT_EN.

Function
- REQ-013 Block converts the FIFO read port (1-cycle registered read latency) into a first-word-fall-through valid/ready stream at a sustained 1 word/clk.
- REQ-014 Storage is a 3-entry register buffer with read and write pointers that wrap modulo 3 (2 -> 0).
- REQ-015 State: inflight flag (1 bit) and occ (2 bits); inflight_next = O_fifo_rinc.
- REQ-016 O_fifo_rinc = !I_fifo_rempty && (occ + inflight) < 3, computed only from registers and I_fifo_rempty; there is no combinational path from I_ready.
- REQ-017 When inflight=1, I_fifo_rdata is written at the write pointer on that edge, and the write pointer advances.
- REQ-018 pop = O_valid && I_ready; O_valid = (occ != 0); O_data = buf[rd_ptr], taken directly from the register.
- REQ-019 occ_next = occ + inflight - pop; a simultaneous arrival and pop leaves occ unchanged, and the pointers both advance.
- REQ-020 Full: when occ + inflight = 3, no rinc is issued, and O_valid holds with O_data stable while I_ready = 0.
- REQ-021 Empty: when I_fifo_rempty = 1, no rinc is issued; O_valid drops after the last buffered word pops.
- REQ-022 Latency: the first word is on O_data with O_valid = 1 two clocks after the edge on which I_fifo_rempty is sampled low (rinc cycle, then data cycle, then buffered).
- REQ-023 O_data and O_valid change only on a pop or on an arrival into an empty buffer.

Reset
- REQ-024 Asserting I_rst_n low immediately clears occ, inflight, both pointers, O_xfer_cnt, O_valid, O_occ, and O_fifo_rinc to 0; buffer contents are don't-care.
- REQ-025 Reset mid-operation discards buffered and in-flight words; the FIFO read side is reset in the same window, which the integrator guarantees.
- REQ-026 After deassertion, the first rinc is issued no earlier than the first clock edge.

Configuration
- REQ-027 Macro FIFO_RD_STREAM_CNT_EN: when defined, O_xfer_cnt increments by 1 per pop and wraps at 2^CSIZE; I_cnt_clr synchronously zeroes it, and clear takes priority over a simultaneous pop.
- REQ-028 Without FIFO_RD_STREAM_CNT_EN, I_cnt_clr and O_xfer_cnt do not exist, and all other behaviour is identical.

Structure
- REQ-029 Shared package fifo_pkg holds: RD_BUF_DEPTH = 3, the pointer-wrap increment function, and the default CSIZE.
- REQ-030 One sub-module, fifo_rd_stream_buf (3-entry register buffer with pointers and occ), is instantiated once; the rinc logic and counter stay in the top level.

Verification
- REQ-031 Stream rate: FIFO preloaded with 0x01..0x10, I_ready = 1 constantly -> O_data 0x01..0x10 in order on 16 consecutive clocks with no O_valid gaps; O_valid first rises 2 clocks after the first empty=0 sample.
- REQ-032 Backpressure: I_ready = 0 with 8 words in the FIFO -> O_occ = 3, O_fifo_rinc = 0, O_data = 0x01 held; I_ready then released -> 0x01..0x08 delivered with none lost or duplicated.
- REQ-033 Wrap: 7 words, with I_ready toggling 1,0,1,0,... -> output order preserved across pointer wraps 2 -> 0; O_occ never exceeds 3.
- REQ-034 Empty boundary: single word 0xA5 -> exactly one rinc pulse, one pop of 0xA5, then O_valid = 0 and O_fifo_rinc = 0 while I_fifo_rempty = 1.
- REQ-035 Mid-stream reset: I_rst_n low with O_occ = 2 and inflight = 1 -> O_valid, O_occ, and O_fifo_rinc are 0 immediately, without a clock edge; after release with both sides reset, new data 0x55 streams correctly.
- REQ-036 Counter (FIFO_RD_STREAM_CNT_EN): 20 pops -> O_xfer_cnt = 20; I_cnt_clr asserted together with a pop -> O_xfer_cnt = 0 on the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: buffer depth,
// default counter width and the modulo-3 pointer increment.
package fifo_pkg;

  localparam int unsigned RD_BUF_DEPTH  = 3;
  localparam int unsigned CSIZE_DEFAULT = 16;

  typedef logic [1:0] rd_ptr_t;

  // Pointers cover 0..RD_BUF_DEPTH-1 and wrap 2 -> 0.
  function automatic rd_ptr_t rd_ptr_inc(input rd_ptr_t p);
    return (p == rd_ptr_t'(RD_BUF_DEPTH - 1)) ? rd_ptr_t'(0) : p + rd_ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// 3-entry register buffer with wrapping read/write pointers and occupancy.
// Output data is taken straight from the entry at the read pointer.
module fifo_rd_stream_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_wr_en,
  input  logic [DSIZE-1:0] I_wdata,
  input  logic             I_pop,
  output logic [DSIZE-1:0] O_rdata,
  output logic [1:0]       O_occ
);

  logic [DSIZE-1:0] mem_q [RD_BUF_DEPTH];
  rd_ptr_t          wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    unique case ({I_wr_en, I_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      occ_q <= occ_d;
      if (I_wr_en) wr_ptr_q <= rd_ptr_inc(wr_ptr_q);
      if (I_pop)   rd_ptr_q <= rd_ptr_inc(rd_ptr_q);
    end
  end

  // Contents are don't-care after reset, so no reset on the data path.
  always_ff @(posedge I_clk) begin
    if (I_wr_en) mem_q[wr_ptr_q] <= I_wdata;
  end

  assign O_rdata = mem_q[rd_ptr_q];
  assign O_occ   = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a registered-read async FIFO port into a first-word-fall-through valid/ready stream.
// Optional pop counter is compiled in with FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned CSIZE = CSIZE_DEFAULT
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
`ifdef FIFO_RD_STREAM_CNT_EN
  input  logic             I_cnt_clr,
  output logic [CSIZE-1:0] O_xfer_cnt,
`endif
  input  logic             I_fifo_rempty,
  output logic             O_fifo_rinc,
  input  logic [DSIZE-1:0] I_fifo_rdata,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [DSIZE-1:0] O_data,
  output logic [1:0]       O_occ
);

  if (CSIZE == 0) begin : g_csize_chk
    $error("CSIZE must be at least 1");
  end

  logic       run_q;
  logic       inflight_q;
  logic       pop;
  logic [2:0] pending;

  // Words already committed: buffered plus the one returning this cycle.
  assign pending = {1'b0, O_occ} + {2'b00, inflight_q};

  // run_q holds off the first read until one edge after reset release.
  assign O_fifo_rinc = run_q && !I_fifo_rempty && (pending < 3'(RD_BUF_DEPTH));
  assign O_valid     = (O_occ != 2'd0);
  assign pop         = O_valid && I_ready;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= O_fifo_rinc;
    end
  end

  fifo_rd_stream_buf #(
    .DSIZE (DSIZE)
  ) u_buf (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_wr_en (inflight_q),
    .I_wdata (I_fifo_rdata),
    .I_pop   (pop),
    .O_rdata (O_data),
    .O_occ   (O_occ)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CSIZE-1:0] xfer_cnt_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      xfer_cnt_q <= '0;
    end else if (I_cnt_clr) begin
      xfer_cnt_q <= '0;
    end else if (pop) begin
      xfer_cnt_q <= xfer_cnt_q + CSIZE'(1);
    end
  end

  assign O_xfer_cnt = xfer_cnt_q;
`endif

endmodule
